inject_ctrl: RTL and testbench

INJECT_CTRL -- requirements
Module: inject_ctrl

---
 rtl/inject_ctrl.sv | 80 ++++++++
 tb/tb_inject_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/inject_ctrl.sv
// inject_ctrl: local-flit FIFO with round-robin injection into free mesh channels; INJ_STARVE_EN adds a starvation flag
module inject_ctrl #(
  parameter logic [2:0] ROUTER_ROW   = 3'd4,
  parameter logic [2:0] ROUTER_COL   = 3'd4,
  parameter logic [3:0] STARVE_LIMIT = 4'd15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] northad,
  input  logic [9:0] southad,
  input  logic [9:0] eastad,
  input  logic [9:0] westad,
  input  logic       loc_valid,
  input  logic [5:0] loc_flit,
  output logic       loc_ready,
  output logic [9:0] nad,
  output logic [9:0] sad,
  output logic [9:0] ead,
  output logic [9:0] wad,
  output logic       self_drop,
  output logic       starve
);
  logic [5:0] mem [4];
  logic [1:0] wr_ptr, rd_ptr, rr_ptr, off, chosen;
  logic [2:0] count, dir;
  logic [3:0] free, rot;
  logic [5:0] head;
  logic [9:0] inj;
  logic       is_self, push, pop;
  assign is_self   = loc_flit == {ROUTER_ROW, ROUTER_COL};
  assign loc_ready = rst_n && (count != 3'd4);
  assign push      = loc_valid && loc_ready && !is_self;
  assign free      = ~{westad[9], eastad[9], southad[9], northad[9]};
  assign pop       = (count != 3'd0) && (|free);
  assign rot       = 4'({free, free} >> rr_ptr);
  assign off       = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
  assign chosen    = rr_ptr + off;
  assign head      = mem[rd_ptr];
  assign dir       = (head[2:0] > ROUTER_COL) ? 3'b000 :
                     (head[2:0] < ROUTER_COL) ? 3'b001 :
                     (head[5:3] > ROUTER_ROW) ? 3'b010 : 3'b011;
  assign inj       = {1'b1, dir, head};
  // FIFO storage needs no reset; occupancy is governed by count
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= loc_flit;
  // FIFO pointers, round-robin pointer and registered channel outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr    <= 2'd0;
      rd_ptr    <= 2'd0;
      count     <= 3'd0;
      rr_ptr    <= 2'd0;
      nad       <= 10'b0;
      sad       <= 10'b0;
      ead       <= 10'b0;
      wad       <= 10'b0;
      self_drop <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + 2'(push);
      rd_ptr    <= rd_ptr + 2'(pop);
      count     <= count + 3'(push) - 3'(pop);
      rr_ptr    <= pop ? chosen + 2'd1 : rr_ptr;
      nad       <= northad[9] ? northad : (pop && chosen == 2'd0) ? inj : 10'b0;
      sad       <= southad[9] ? southad : (pop && chosen == 2'd1) ? inj : 10'b0;
      ead       <= eastad[9]  ? eastad  : (pop && chosen == 2'd2) ? inj : 10'b0;
      wad       <= westad[9]  ? westad  : (pop && chosen == 2'd3) ? inj : 10'b0;
      self_drop <= loc_valid && loc_ready && is_self;
    end
`ifdef INJ_STARVE_EN
  logic [3:0] starve_cnt;
  // saturating count of cycles a queued flit finds every channel busy
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) starve_cnt <= 4'd0;
    else if (count == 3'd0 || pop) starve_cnt <= 4'd0;
    else if (starve_cnt != 4'hf) starve_cnt <= starve_cnt + 4'd1;
  assign starve = starve_cnt >= STARVE_LIMIT;
`else
  assign starve = 1'b0;
`endif
endmodule

// File: tb/tb_inject_ctrl.sv
// tb_inject_ctrl: directed table, corner sequences and randomized model check for inject_ctrl
module tb_inject_ctrl;
  localparam logic [2:0] RR = 3'd4;
  localparam logic [2:0] RC = 3'd4;
  localparam int LIMIT = 15;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [9:0] northad, southad, eastad, westad, nad, sad, ead, wad;
  logic loc_valid, loc_ready, self_drop, starve;
  logic [5:0] loc_flit;
  int total = 0, bad = 0;
  logic [5:0] mq[$];
  int m_rr, m_cnt;
  typedef struct {
    logic [9:0] n, s, e, w;
    logic lv;
    logic [5:0] lf;
    logic [9:0] xn, xs, xe, xw;
    logic xr, xd;
  } vec_t;
  vec_t tbl[19];
  localparam logic [9:0] A = 10'h3aa, B = 10'h255, C = 10'h2f0, D = 10'h30f, Z = 10'h000;

  always #5 clk = ~clk;

  inject_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .northad(northad), .southad(southad), .eastad(eastad), .westad(westad),
    .loc_valid(loc_valid), .loc_flit(loc_flit), .loc_ready(loc_ready),
    .nad(nad), .sad(sad), .ead(ead), .wad(wad),
    .self_drop(self_drop), .starve(starve)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [9:0] n, s, e, w, input logic lv, input logic [5:0] lf);
    northad = n; southad = s; eastad = e; westad = w; loc_valid = lv; loc_flit = lf;
  endtask

  task automatic do_reset();
    drive(Z, Z, Z, Z, 1'b0, 6'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_outs", {nad, sad, ead, wad}, 40'd0);
    chk("rst_flags", {loc_ready, self_drop, starve}, 3'b000);
    @(posedge clk); #1 rst_n = 1'b1;
    #1 chk("rst_ready_after", loc_ready, 1'b1);
    mq.delete(); m_rr = 0; m_cnt = 0;
  endtask

  function automatic logic [2:0] xy_dir(input logic [5:0] f);
    if (f[2:0] > RC) return 3'b000;
    if (f[2:0] < RC) return 3'b001;
    if (f[5:3] > RR) return 3'b010;
    return 3'b011;
  endfunction

  initial begin
    tbl[0]  = '{Z, Z, Z, Z, 1'b1, 6'o47, Z, Z, Z, Z, 1'b1, 1'b0};
    tbl[1]  = '{Z, Z, Z, Z, 1'b0, 6'o00, 10'b1000100111, Z, Z, Z, 1'b1, 1'b0};
    tbl[2]  = '{A, B, C, Z, 1'b1, 6'o00, A, B, C, Z, 1'b1, 1'b0};
    tbl[3]  = '{A, B, C, Z, 1'b1, 6'o14, A, B, C, 10'b1001000000, 1'b1, 1'b0};
    tbl[4]  = '{A, Z, Z, Z, 1'b0, 6'o00, A, 10'b1011001100, Z, Z, 1'b1, 1'b0};
    tbl[5]  = '{A, B, C, D, 1'b1, 6'o22, A, B, C, D, 1'b1, 1'b0};
    tbl[6]  = '{A, B, C, D, 1'b1, 6'o33, A, B, C, D, 1'b1, 1'b0};
    tbl[7]  = '{A, B, C, D, 1'b1, 6'o55, A, B, C, D, 1'b1, 1'b0};
    tbl[8]  = '{A, B, C, D, 1'b1, 6'o66, A, B, C, D, 1'b1, 1'b0};
    tbl[9]  = '{A, B, C, D, 1'b1, 6'o70, A, B, C, D, 1'b0, 1'b0};
    tbl[10] = '{A, B, C, D, 1'b0, 6'o00, A, B, C, D, 1'b0, 1'b0};
    tbl[11] = '{Z, Z, Z, Z, 1'b1, 6'o11, Z, Z, 10'b1001010010, Z, 1'b0, 1'b0};
    tbl[12] = '{Z, Z, Z, Z, 1'b0, 6'o00, Z, Z, Z, 10'b1001011011, 1'b1, 1'b0};
    tbl[13] = '{Z, Z, Z, Z, 1'b0, 6'o00, 10'b1000101101, Z, Z, Z, 1'b1, 1'b0};
    tbl[14] = '{Z, Z, Z, Z, 1'b0, 6'o00, Z, 10'b1000110110, Z, Z, 1'b1, 1'b0};
    tbl[15] = '{Z, Z, Z, Z, 1'b1, 6'o44, Z, Z, Z, Z, 1'b1, 1'b1};
    tbl[16] = '{Z, Z, Z, Z, 1'b0, 6'o00, Z, Z, Z, Z, 1'b1, 1'b0};
    tbl[17] = '{Z, Z, Z, Z, 1'b1, 6'o64, Z, Z, Z, Z, 1'b1, 1'b0};
    tbl[18] = '{Z, Z, Z, Z, 1'b0, 6'o00, Z, Z, 10'b1010110100, Z, 1'b1, 1'b0};

    do_reset();
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].n, tbl[i].s, tbl[i].e, tbl[i].w, tbl[i].lv, tbl[i].lf);
      #1 chk($sformatf("tbl%0d_ready", i), loc_ready, tbl[i].xr);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_nad", i), nad, tbl[i].xn);
      chk($sformatf("tbl%0d_sad", i), sad, tbl[i].xs);
      chk($sformatf("tbl%0d_ead", i), ead, tbl[i].xe);
      chk($sformatf("tbl%0d_wad", i), wad, tbl[i].xw);
      chk($sformatf("tbl%0d_drop", i), self_drop, tbl[i].xd);
    end

    do_reset();
    drive(A, B, C, D, 1'b1, 6'o11);
    @(posedge clk); #1 loc_flit = 6'o22;
    @(posedge clk); #1 loc_valid = 1'b0;
    #2 chk("midrst_before", {nad, sad, ead, wad}, {A, B, C, D});
    rst_n = 1'b0;
    #1 chk("midrst_outs", {nad, sad, ead, wad}, 40'd0);
    chk("midrst_ready", loc_ready, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    drive(Z, Z, Z, Z, 1'b0, 6'd0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1 chk($sformatf("midrst_empty%0d", i), {nad, sad, ead, wad}, 40'd0);
    end

`ifdef INJ_STARVE_EN
    do_reset();
    drive(A, B, C, D, 1'b1, 6'o11);
    @(posedge clk); #1 loc_valid = 1'b0;
    for (int i = 0; i < 14; i++) @(posedge clk);
    #1 chk("starve_at14", starve, 1'b0);
    @(posedge clk); #1 chk("starve_at15", starve, 1'b1);
    westad = Z;
    @(posedge clk); #1;
    chk("starve_inj_wad", wad, 10'b1001001001);
    chk("starve_clear", starve, 1'b0);
`endif

    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [9:0] ins[4];
      logic [9:0] xo[4];
      int ch, pct, pre;
      logic lv, xd, xs;
      logic [5:0] lf;
      pct = 30 * (1 + (c / 500) % 3);
      for (int k = 0; k < 4; k++)
        ins[k] = {($urandom_range(0, 99) < pct) ? 1'b1 : 1'b0, 9'($urandom)};
      lv = $urandom_range(0, 3) != 0;
      lf = ($urandom_range(0, 7) == 0) ? {RR, RC} : 6'($urandom);
      drive(ins[0], ins[1], ins[2], ins[3], lv, lf);
      #1 chk("rand_ready", loc_ready, mq.size() < 4);
      pre = mq.size();
      ch = -1;
      if (pre > 0)
        for (int k = 0; k < 4; k++)
          if (ch < 0 && !ins[(m_rr + k) % 4][9]) ch = (m_rr + k) % 4;
      for (int k = 0; k < 4; k++)
        xo[k] = ins[k][9] ? ins[k] : (k == ch) ? {1'b1, xy_dir(mq[0]), mq[0]} : 10'b0;
      if (ch >= 0) begin
        void'(mq.pop_front());
        m_rr = (ch + 1) % 4;
      end
      xd = lv && pre < 4 && lf == {RR, RC};
      if (lv && pre < 4 && lf != {RR, RC}) mq.push_back(lf);
`ifdef INJ_STARVE_EN
      if (pre == 0 || ch >= 0) m_cnt = 0;
      else if (m_cnt < 15) m_cnt++;
      xs = m_cnt >= LIMIT;
`else
      xs = 1'b0;
`endif
      @(posedge clk); #1;
      chk("rand_nad", nad, xo[0]);
      chk("rand_sad", sad, xo[1]);
      chk("rand_ead", ead, xo[2]);
      chk("rand_wad", wad, xo[3]);
      chk("rand_drop", self_drop, xd);
      chk("rand_starve", starve, xs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
